icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 158 +++++++++++++++
 tb/tb_icache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : icache                                                        |
// | Purpose  : Direct-mapped, one-word-per-line instruction cache sitting    |
// |            between the instruction fetcher and the memory controller.    |
// |            Hits answer one cycle after the lookup. A miss raises a       |
// |            level request to the memory controller and waits in MISS      |
// |            until the fill word arrives.                                  |
// | Ports    : clk_in, rst_in        clock / sync active-high reset          |
// |            rdy_in                global enable (low freezes everything)  |
// |            valid_if_in, pc_if_in fetch request from the fetcher          |
// |            inst_if_out, rdy_if_out   response to the fetcher (pulse)     |
// |            rdy_inst_mc_out, inst_addr_mc_out  miss request (level)       |
// |            inst_mc_in, rdy_inst_mc_in         fill word (pulse)          |
// |            refresh_rob_cdb_in    pipeline flush                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module icache #(
  parameter int ICACHE_LINES = 256,
  parameter int INDEX_BITS   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        valid_if_in,
  input  logic [31:0] pc_if_in,
  output logic [31:0] inst_if_out,
  output logic        rdy_if_out,
  output logic        rdy_inst_mc_out,
  output logic [31:0] inst_addr_mc_out,
  input  logic [31:0] inst_mc_in,
  input  logic        rdy_inst_mc_in,
  input  logic        refresh_rob_cdb_in
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  // Control and output registers
  state_e            state_q,   state_d;
  logic [31:0]       miss_pc_q, miss_pc_d;
  logic [31:0]       inst_q,    inst_d;
  logic              rdy_if_q,  rdy_if_d;
  logic              req_q,     req_d;
  logic [31:0]       addr_q,    addr_d;

  // Line storage: valid bits are reset, tag/data are not
  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]     tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_miss_idx;
  logic [TAG_BITS-1:0]   w_miss_tag;
  logic                  w_hit;
  logic                  fill_en;
  logic                  unused_pc_lo;

  assign w_idx      = pc_if_in[INDEX_BITS+1:2];
  assign w_tag      = pc_if_in[31:INDEX_BITS+2];
  assign w_miss_idx = miss_pc_q[INDEX_BITS+1:2];
  assign w_miss_tag = miss_pc_q[31:INDEX_BITS+2];
  assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  // Fetch addresses are word aligned; the byte offset carries no information
  assign unused_pc_lo = ^pc_if_in[1:0];

  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    inst_d    = inst_q;
    rdy_if_d  = 1'b0;       // response is a single-cycle pulse
    req_d     = req_q;
    addr_d    = addr_q;
    fill_en   = 1'b0;

    if (refresh_rob_cdb_in) begin
      // Flush wins over everything, including a coincident fill word
      state_d = S_IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // While a response is on the bus the fetcher's pc may still be the
          // old one, so no new lookup is accepted that cycle.
          if (valid_if_in && !rdy_if_q) begin
            if (w_hit) begin
              rdy_if_d = 1'b1;
              inst_d   = data_q[w_idx];
            end else begin
              miss_pc_d = pc_if_in;
              req_d     = 1'b1;
              addr_d    = pc_if_in;
              state_d   = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (rdy_inst_mc_in) begin
            fill_en = 1'b1;
            req_d   = 1'b0;
            state_d = S_IDLE;
            // Only answer if the fetcher still wants this exact address
            if (valid_if_in && (pc_if_in == miss_pc_q)) begin
              rdy_if_d = 1'b1;
              inst_d   = inst_mc_in;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      miss_pc_q <= '0;
      inst_q    <= '0;
      rdy_if_q  <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      inst_q    <= inst_d;
      rdy_if_q  <= rdy_if_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (rdy_in && fill_en) begin
      valid_q[w_miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_en) begin
      tag_q[w_miss_idx]  <= w_miss_tag;
      data_q[w_miss_idx] <= inst_mc_in;
    end
  end

  assign inst_if_out      = inst_q;
  assign rdy_if_out       = rdy_if_q;
  assign rdy_inst_mc_out  = req_q;
  assign inst_addr_mc_out = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_icache                                                     |
// | Purpose  : Self-checking bench for icache. A transaction-level model     |
// |            tracks which pc occupies each line and what memory holds at   |
// |            every address; directed scenarios are followed by random      |
// |            fetches over a small set of conflicting addresses.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_icache;

  localparam int LINES = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        valid_if;
  logic [31:0] pc_if;
  logic [31:0] inst_if;
  logic        rdy_if;
  logic        req_mc;
  logic [31:0] addr_mc;
  logic [31:0] inst_mc;
  logic        rdy_mc;
  logic        refresh;

  int total = 0;
  int bad   = 0;

  // Model: which pc currently lives at each index, and memory contents
  logic [31:0] resident [int];
  logic [31:0] mem [logic [31:0]];

  icache #(.ICACHE_LINES(LINES), .INDEX_BITS(8)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .rdy_in             (rdy),
    .valid_if_in        (valid_if),
    .pc_if_in           (pc_if),
    .inst_if_out        (inst_if),
    .rdy_if_out         (rdy_if),
    .rdy_inst_mc_out    (req_mc),
    .inst_addr_mc_out   (addr_mc),
    .inst_mc_in         (inst_mc),
    .rdy_inst_mc_in     (rdy_mc),
    .refresh_rob_cdb_in (refresh)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return resident.exists(idx_of(a)) && (resident[idx_of(a)] == a);
  endfunction

  // One full fetch: lookup, optional miss with lat wait cycles, response
  task automatic fetch(input logic [31:0] pc, input int lat);
    logic [31:0] w;
    bit          hit;
    hit = is_hit(pc);
    w   = memword(pc);
    valid_if = 1'b1;
    pc_if    = pc;
    step();
    if (hit) begin
      chk("hit_rdy",   {31'b0, rdy_if}, 32'd1);
      chk("hit_inst",  inst_if, w);
      chk("hit_noreq", {31'b0, req_mc}, 32'd0);
    end else begin
      chk("miss_req",  {31'b0, req_mc}, 32'd1);
      chk("miss_addr", addr_mc, pc);
      chk("miss_rdy",  {31'b0, rdy_if}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        step();
        chk("miss_hold_req",  {31'b0, req_mc}, 32'd1);
        chk("miss_hold_addr", addr_mc, pc);
      end
      rdy_mc  = 1'b1;
      inst_mc = w;
      step();
      rdy_mc  = 1'b0;
      chk("fill_rdy",  {31'b0, rdy_if}, 32'd1);
      chk("fill_inst", inst_if, w);
      chk("fill_req",  {31'b0, req_mc}, 32'd0);
      resident[idx_of(pc)] = pc;
    end
    valid_if = 1'b0;
    step();
    chk("pulse_end", {31'b0, rdy_if}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; rdy = 1'b1; valid_if = 1'b0; pc_if = '0;
    inst_mc = '0; rdy_mc = 1'b0; refresh = 1'b0;
    step(); step();
    chk("rst_inst", inst_if, 32'd0);
    chk("rst_rdy",  {31'b0, rdy_if}, 32'd0);
    chk("rst_req",  {31'b0, req_mc}, 32'd0);
    chk("rst_addr", addr_mc, 32'd0);
    rst = 1'b0;
    step();

    // Cold miss, then hit
    mem[32'h1000] = 32'h0000_0013;
    fetch(32'h1000, 6);
    fetch(32'h1000, 0);

    // Held request after a hit: the cycle carrying the response takes no lookup
    valid_if = 1'b1; pc_if = 32'h1000;
    step(); chk("b2b_rdy1", {31'b0, rdy_if}, 32'd1); chk("b2b_inst", inst_if, 32'h13);
    step(); chk("b2b_gap",  {31'b0, rdy_if}, 32'd0);
    step(); chk("b2b_rdy2", {31'b0, rdy_if}, 32'd1);
    valid_if = 1'b0;
    step(); chk("b2b_end",  {31'b0, rdy_if}, 32'd0);

    // Conflict: same index, different tag
    fetch(32'h1400, 3);
    fetch(32'h1000, 2);
    fetch(32'h1400, 1);

    // Flush mid-miss with coincident fill word
    valid_if = 1'b1; pc_if = 32'h1000;
    step(); chk("fl_req", {31'b0, req_mc}, 32'd1);
    step(); step();
    refresh = 1'b1; rdy_mc = 1'b1; inst_mc = 32'hDEAD_BEEF;
    step();
    refresh = 1'b0; rdy_mc = 1'b0; valid_if = 1'b0;
    chk("fl_rdy", {31'b0, rdy_if}, 32'd0);
    chk("fl_req_drop", {31'b0, req_mc}, 32'd0);
    step();
    chk("fl_rdy2", {31'b0, rdy_if}, 32'd0);
    chk("fl_notfilled", {31'b0, is_hit(32'h1000)}, 32'd0);
    fetch(32'h1000, 2);

    // Stall during the miss and during the response pulse
    w = memword(32'h3000);
    valid_if = 1'b1; pc_if = 32'h3000;
    step(); chk("st_req", {31'b0, req_mc}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_req_hold",  {31'b0, req_mc}, 32'd1);
      chk("st_addr_hold", addr_mc, 32'h3000);
    end
    rdy = 1'b1; rdy_mc = 1'b1; inst_mc = w;
    step();
    rdy_mc = 1'b0;
    chk("st_rdy", {31'b0, rdy_if}, 32'd1);
    chk("st_inst", inst_if, w);
    valid_if = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_pulse_hold", {31'b0, rdy_if}, 32'd1);
      chk("st_inst_hold",  inst_if, w);
    end
    rdy = 1'b1;
    step(); chk("st_pulse_end", {31'b0, rdy_if}, 32'd0);
    step(); chk("st_one_resp",  {31'b0, rdy_if}, 32'd0);
    resident[idx_of(32'h3000)] = 32'h3000;

    // Fetcher redirect during a miss
    w = memword(32'h1000);
    valid_if = 1'b1; pc_if = 32'h1000;
    step(); chk("rd_addr", addr_mc, 32'h1000);
    step();
    pc_if = 32'h2000;
    step(); chk("rd_addr_kept", addr_mc, 32'h1000);
    rdy_mc = 1'b1; inst_mc = w;
    step();
    rdy_mc = 1'b0; valid_if = 1'b0;
    chk("rd_no_resp", {31'b0, rdy_if}, 32'd0);
    chk("rd_req_drop", {31'b0, req_mc}, 32'd0);
    resident[idx_of(32'h1000)] = 32'h1000;
    step();
    fetch(32'h1000, 0);
    fetch(32'h2000, 3);

    // Reset mid-miss, late fill pulse ignored
    valid_if = 1'b1; pc_if = 32'h4000;
    step(); chk("rm_req", {31'b0, req_mc}, 32'd1);
    rst = 1'b1;
    step();
    chk("rm_req0",  {31'b0, req_mc}, 32'd0);
    chk("rm_addr0", addr_mc, 32'd0);
    chk("rm_rdy0",  {31'b0, rdy_if}, 32'd0);
    chk("rm_inst0", inst_if, 32'd0);
    rst = 1'b0; valid_if = 1'b0; rdy_mc = 1'b1; inst_mc = 32'h1234_5678;
    step();
    rdy_mc = 1'b0;
    chk("rm_ignored_rdy", {31'b0, rdy_if}, 32'd0);
    chk("rm_ignored_req", {31'b0, req_mc}, 32'd0);
    resident.delete();
    fetch(32'h2000, 1);

    // Random fetches over 4 indices x 4 tags
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2);
      fetch(pc, int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
